// File: rtl/alu_multiciclo.sv
// Sequential ALU: registered one-cycle logic/arith ops plus iterative shift-add MULTU and
// restoring DIVU producing a HI/LO pair. Define ALU_DIV_EN to build the divider.
module alu_multiciclo #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inicio,
  input  logic [WIDTH-1:0] operador1,
  input  logic [WIDTH-1:0] operador2,
  input  logic [3:0]       selector,
  output logic             listo,
  output logic             valido,
  output logic [WIDTH-1:0] resultado,
  output logic [WIDTH-1:0] resultado_hi,
  output logic             ZF,
  output logic             OF,
  output logic             div_cero
);

  localparam int CW = $clog2(WIDTH + 1);

  localparam logic [3:0] OP_AND   = 4'b0000;
  localparam logic [3:0] OP_OR    = 4'b0001;
  localparam logic [3:0] OP_ADD   = 4'b0010;
  localparam logic [3:0] OP_XOR   = 4'b0011;
  localparam logic [3:0] OP_SUB   = 4'b0110;
  localparam logic [3:0] OP_SLT   = 4'b0111;
  localparam logic [3:0] OP_SLTU  = 4'b1000;
  localparam logic [3:0] OP_NOR   = 4'b1100;
  localparam logic [3:0] OP_MULTU = 4'b1001;
`ifdef ALU_DIV_EN
  localparam logic [3:0] OP_DIVU  = 4'b1010;
`endif

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DIV  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] opa_q, opa_d;
  logic [WIDTH-1:0] acc_hi_q, acc_hi_d;
  logic [WIDTH-1:0] acc_lo_q, acc_lo_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [WIDTH-1:0] res_hi_q, res_hi_d;
  logic             zf_q, zf_d;
  logic             of_q, of_d;
  logic             dz_q, dz_d;
  logic             vld_q, vld_d;

  // Signed overflow: operands effectively share a sign but the result's sign differs.
  function automatic logic sign_ovf(input logic sa, input logic sb, input logic sr,
                                    input logic is_sub);
    logic sb_eff;
    sb_eff = is_sub ? ~sb : sb;
    return (sa == sb_eff) && (sr != sa);
  endfunction

  logic signed [WIDTH-1:0] a_s, b_s;
  logic        [WIDTH-1:0] suma, resta, res1;
  logic                    of1;

  assign a_s   = operador1;
  assign b_s   = operador2;
  assign suma  = operador1 + operador2;
  assign resta = operador1 - operador2;

  always_comb begin
    res1 = '0;
    of1  = 1'b0;
    case (selector)
      OP_AND:  res1 = operador1 & operador2;
      OP_OR:   res1 = operador1 | operador2;
      OP_XOR:  res1 = operador1 ^ operador2;
      OP_NOR:  res1 = ~(operador1 | operador2);
      OP_ADD: begin
        res1 = suma;
        of1  = sign_ovf(operador1[WIDTH-1], operador2[WIDTH-1], suma[WIDTH-1], 1'b0);
      end
      OP_SUB: begin
        res1 = resta;
        of1  = sign_ovf(operador1[WIDTH-1], operador2[WIDTH-1], resta[WIDTH-1], 1'b1);
      end
      OP_SLT:  res1 = {{(WIDTH-1){1'b0}}, (a_s < b_s)};
      OP_SLTU: res1 = {{(WIDTH-1){1'b0}}, (operador1 < operador2)};
      default: res1 = '0;
    endcase
  end

  // Shift-add step: {acc_hi, acc_lo} holds partial product over the remaining multiplier bits.
  logic [WIDTH:0]   mul_sum;
  logic [WIDTH-1:0] mul_hi_nx, mul_lo_nx;

  assign mul_sum   = {1'b0, acc_hi_q} + (acc_lo_q[0] ? {1'b0, opa_q} : '0);
  assign mul_hi_nx = mul_sum[WIDTH:1];
  assign mul_lo_nx = {mul_sum[0], acc_lo_q[WIDTH-1:1]};

`ifdef ALU_DIV_EN
  // Restoring step: acc_hi is the partial remainder, acc_lo shifts dividend out and quotient in.
  logic [WIDTH:0]   div_sh, div_dif;
  logic             div_ge;
  logic [WIDTH-1:0] div_hi_nx, div_lo_nx;

  assign div_sh    = {acc_hi_q, acc_lo_q[WIDTH-1]};
  assign div_ge    = (div_sh >= {1'b0, opa_q});
  assign div_dif   = div_sh - {1'b0, opa_q};
  assign div_hi_nx = div_ge ? div_dif[WIDTH-1:0] : div_sh[WIDTH-1:0];
  assign div_lo_nx = {acc_lo_q[WIDTH-2:0], div_ge};
`endif

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    opa_d    = opa_q;
    acc_hi_d = acc_hi_q;
    acc_lo_d = acc_lo_q;
    res_d    = res_q;
    res_hi_d = res_hi_q;
    zf_d     = zf_q;
    of_d     = of_q;
    dz_d     = dz_q;
    vld_d    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (inicio) begin
          case (selector)
            OP_MULTU: begin
              state_d  = S_MUL;
              cnt_d    = '0;
              opa_d    = operador1;
              acc_hi_d = '0;
              acc_lo_d = operador2;
            end
`ifdef ALU_DIV_EN
            OP_DIVU: begin
              if (operador2 == '0) begin
                res_d    = '1;
                res_hi_d = operador1;
                zf_d     = 1'b0;
                of_d     = 1'b0;
                dz_d     = 1'b1;
                vld_d    = 1'b1;
              end else begin
                state_d  = S_DIV;
                cnt_d    = '0;
                opa_d    = operador2;
                acc_hi_d = '0;
                acc_lo_d = operador1;
              end
            end
`endif
            default: begin
              res_d    = res1;
              res_hi_d = '0;
              zf_d     = (res1 == '0);
              of_d     = of1;
              dz_d     = 1'b0;
              vld_d    = 1'b1;
            end
          endcase
        end
      end
      S_MUL: begin
        acc_hi_d = mul_hi_nx;
        acc_lo_d = mul_lo_nx;
        cnt_d    = cnt_q + CW'(1);
        if (cnt_q == CW'(WIDTH - 1)) begin
          state_d  = S_IDLE;
          cnt_d    = '0;
          res_d    = mul_lo_nx;
          res_hi_d = mul_hi_nx;
          zf_d     = (mul_lo_nx == '0);
          of_d     = 1'b0;
          dz_d     = 1'b0;
          vld_d    = 1'b1;
        end
      end
`ifdef ALU_DIV_EN
      S_DIV: begin
        acc_hi_d = div_hi_nx;
        acc_lo_d = div_lo_nx;
        cnt_d    = cnt_q + CW'(1);
        if (cnt_q == CW'(WIDTH - 1)) begin
          state_d  = S_IDLE;
          cnt_d    = '0;
          res_d    = div_lo_nx;
          res_hi_d = div_hi_nx;
          zf_d     = (div_lo_nx == '0);
          of_d     = 1'b0;
          dz_d     = 1'b0;
          vld_d    = 1'b1;
        end
      end
`endif
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Working registers carry no reset: they are always loaded before use.
  always_ff @(posedge clk) begin
    opa_q    <= opa_d;
    acc_hi_q <= acc_hi_d;
    acc_lo_q <= acc_lo_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      res_q    <= '0;
      res_hi_q <= '0;
      zf_q     <= 1'b1;
      of_q     <= 1'b0;
      dz_q     <= 1'b0;
      vld_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      res_q    <= res_d;
      res_hi_q <= res_hi_d;
      zf_q     <= zf_d;
      of_q     <= of_d;
      dz_q     <= dz_d;
      vld_q    <= vld_d;
    end
  end

  assign listo        = (state_q == S_IDLE);
  assign valido       = vld_q;
  assign resultado    = res_q;
  assign resultado_hi = res_hi_q;
  assign ZF           = zf_q;
  assign OF           = of_q;
  assign div_cero     = dz_q;

endmodule

// File: tb/tb_alu_multiciclo.sv
// Bench for alu_multiciclo (WIDTH=32): arithmetic reference model checked every cycle,
// plus directed vectors with literal expectations.
module tb_alu_multiciclo;
  localparam int W = 32;

  logic          clk = 1'b0;
  logic          rst, inicio;
  logic [W-1:0]  operador1, operador2;
  logic [3:0]    selector;
  logic          listo, valido, ZF, OF, div_cero;
  logic [W-1:0]  resultado, resultado_hi;

  int checks = 0;
  int errors = 0;

  alu_multiciclo #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .inicio(inicio), .operador1(operador1), .operador2(operador2),
    .selector(selector), .listo(listo), .valido(valido), .resultado(resultado),
    .resultado_hi(resultado_hi), .ZF(ZF), .OF(OF), .div_cero(div_cero)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Reference: plain integer arithmetic on the operation's meaning.
  function automatic void model_op(input logic [31:0] a, input logic [31:0] b,
                                   input logic [3:0] s, output logic [31:0] r,
                                   output logic [31:0] h, output logic of,
                                   output logic dz, output bit multi);
    longint sa, sb, t;
    longint unsigned p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    r = 0; h = 0; of = 0; dz = 0; multi = 0;
    case (s)
      4'd0:  r = a & b;
      4'd1:  r = a | b;
      4'd3:  r = a ^ b;
      4'd12: r = ~(a | b);
      4'd2:  begin t = sa + sb; r = t[31:0]; of = (t > 64'sd2147483647) || (t < -64'sd2147483648); end
      4'd6:  begin t = sa - sb; r = t[31:0]; of = (t > 64'sd2147483647) || (t < -64'sd2147483648); end
      4'd7:  r = (sa < sb) ? 32'd1 : 32'd0;
      4'd8:  r = (a < b) ? 32'd1 : 32'd0;
      4'd9:  begin p = longint'(a) * longint'(b); r = p[31:0]; h = p[63:32]; multi = 1; end
`ifdef ALU_DIV_EN
      4'd10: begin
        if (b == 0) begin r = 32'hFFFF_FFFF; h = a; dz = 1; end
        else begin r = a / b; h = a % b; multi = 1; end
      end
`endif
      default: r = 0;
    endcase
  endfunction

  bit          m_ok = 0;
  int          busy = 0;
  logic        m_vld, m_zf, m_of, m_dz, m_listo;
  logic [31:0] m_res, m_hi, p_res, p_hi;

  always @(posedge clk) begin
    logic [31:0] r, h;
    logic        o, d;
    bit          multi;
    if (rst) begin
      m_ok = 1; busy = 0; m_vld = 0;
      m_res = 0; m_hi = 0; m_zf = 1; m_of = 0; m_dz = 0;
    end else begin
      m_vld = 0;
      if (busy > 0) begin
        busy--;
        if (busy == 0) begin
          m_vld = 1; m_res = p_res; m_hi = p_hi; m_zf = (p_res == 0); m_of = 0; m_dz = 0;
        end
      end else if (inicio) begin
        model_op(operador1, operador2, selector, r, h, o, d, multi);
        if (multi) begin
          busy = W; p_res = r; p_hi = h;
        end else begin
          m_vld = 1; m_res = r; m_hi = h; m_zf = (r == 0); m_of = o; m_dz = d;
        end
      end
    end
    m_listo = (busy == 0);
  end

  always @(negedge clk) begin
    if (m_ok) begin
      chk("valido", valido, m_vld);
      chk("listo", listo, m_listo);
      chk("resultado", resultado, m_res);
      chk("resultado_hi", resultado_hi, m_hi);
      chk("ZF", ZF, m_zf);
      chk("OF", OF, m_of);
      chk("div_cero", div_cero, m_dz);
    end
  end

  task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic [3:0] s,
                        output int lat);
    operador1 = a; operador2 = b; selector = s; inicio = 1'b1;
    @(negedge clk);
    inicio = 1'b0;
    lat = 1;
    while (valido !== 1'b1 && lat < 60) begin
      @(negedge clk);
      lat++;
    end
    if (lat >= 60) chk("valido_timeout", valido, 1);
  endtask

  initial begin
    int lat;
    rst = 1'b1; inicio = 1'b0; operador1 = '0; operador2 = '0; selector = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk("rst_listo", listo, 1);
    chk("rst_res", resultado, 0);
    chk("rst_zf", ZF, 1);

    run_op(32'h7FFF_FFFF, 32'd1, 4'b0010, lat);
    chk("add_lat", lat, 1);
    chk("add_res", resultado, 32'h8000_0000);
    chk("add_of", OF, 1);
    chk("add_zf", ZF, 0);

    run_op(32'd5, 32'd5, 4'b0110, lat);
    chk("sub_res", resultado, 0);
    chk("sub_zf", ZF, 1);
    chk("sub_of", OF, 0);

    run_op(32'hFFFF_FFFF, 32'd1, 4'b0111, lat);
    chk("slt_res", resultado, 1);
    run_op(32'hFFFF_FFFF, 32'd1, 4'b1000, lat);
    chk("sltu_res", resultado, 0);
    run_op(32'h0000_F0F0, 32'h0000_FF00, 4'b0011, lat);
    chk("xor_res", resultado, 32'h0000_0FF0);
    run_op(32'd0, 32'd0, 4'b1100, lat);
    chk("nor_res", resultado, 32'hFFFF_FFFF);

    // MULTU with a second inicio that must be ignored while busy.
    operador1 = 32'hFFFF_FFFF; operador2 = 32'hFFFF_FFFF; selector = 4'b1001; inicio = 1'b1;
    @(negedge clk);
    lat = 1;
    chk("mul_busy_listo", listo, 0);
    operador1 = 32'd2; operador2 = 32'd3; selector = 4'b0010;
    @(negedge clk);
    lat = 2;
    inicio = 1'b0;
    while (valido !== 1'b1 && lat < 60) begin
      @(negedge clk);
      lat++;
    end
    chk("mul_lat", lat, 33);
    chk("mul_hi", resultado_hi, 32'hFFFF_FFFE);
    chk("mul_lo", resultado, 32'h0000_0001);

    // Issued in the valido cycle of the multiply.
    run_op(32'h0000_00F0, 32'h0000_000F, 4'b0001, lat);
    chk("b2b_lat", lat, 1);
    chk("b2b_res", resultado, 32'h0000_00FF);
    chk("b2b_hi", resultado_hi, 0);

`ifdef ALU_DIV_EN
    run_op(32'd100, 32'd7, 4'b1010, lat);
    chk("div_lat", lat, 33);
    chk("div_q", resultado, 14);
    chk("div_r", resultado_hi, 2);
    run_op(32'd9, 32'd0, 4'b1010, lat);
    chk("div0_lat", lat, 1);
    chk("div0_res", resultado, 32'hFFFF_FFFF);
    chk("div0_hi", resultado_hi, 9);
    chk("div0_flag", div_cero, 1);
`else
    run_op(32'd9, 32'd0, 4'b1010, lat);
    chk("nodiv_lat", lat, 1);
    chk("nodiv_res", resultado, 0);
    chk("nodiv_hi", resultado_hi, 0);
    chk("nodiv_zf", ZF, 1);
    chk("nodiv_dz", div_cero, 0);
`endif

    run_op(32'd3, 32'd5, 4'b0100, lat);
    chk("bad_op_lat", lat, 1);
    chk("bad_op_res", resultado, 0);
    chk("bad_op_zf", ZF, 1);

    run_op(32'h0001_0000, 32'h0001_0003, 4'b1001, lat);
    chk("mul2_hi", resultado_hi, 32'h0000_0001);
    chk("mul2_lo", resultado, 32'h0003_0000);

    // Reset ten cycles into a multiply.
    operador1 = 32'd3; operador2 = 32'd4; selector = 4'b1001; inicio = 1'b1;
    @(negedge clk);
    inicio = 1'b0;
    repeat (9) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("mrst_listo", listo, 1);
    chk("mrst_valido", valido, 0);
    chk("mrst_res", resultado, 0);
    chk("mrst_hi", resultado_hi, 0);
    chk("mrst_zf", ZF, 1);

    run_op(32'd2, 32'd3, 4'b0010, lat);
    chk("post_rst_lat", lat, 1);
    chk("post_rst_res", resultado, 5);

    repeat (3) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
